// File: rtl/ysyx_22041207_mem_arbiter.sv
// Purpose : arbitrates the fetch (IFU) and load/store (LSU) ports onto one memory port, one transaction at a time.
// Latency : request seen in IDLE -> grant pulse next cycle; best case 3 cycles per transaction (IDLE, BUSY, RESP).
// Backpressure: the loser holds its request until granted; BUSY waits on mem_ready and RESP waits on mem_rvalid, both bounded by the timeout.
//
// Ports
//   clk, rst                      : clock (rising edge), asynchronous active-high reset
//   if_req/if_addr                : fetch request, held until if_gnt
//   if_gnt/if_rvalid/if_rdata     : fetch accept pulse, response pulse and data
//   ls_req/ls_wen/ls_addr/...     : load/store request with store data, byte mask and read byte count
//   ls_gnt/ls_rvalid/ls_rdata     : load/store accept pulse, response pulse and data
//   mem_*                         : downstream memory request (payload held for the whole BUSY state)
//   mem_ready/mem_rvalid/mem_rdata: memory accept and response
//   err                           : one-cycle pulse when a transaction is aborted by the timeout
//
// Parameter TIMEOUT_CYCLES: cycles spent in BUSY/RESP before abort; 0 disables the timeout.
// Build option YSYX_22041207_ARB_RR_EN: defined -> round-robin arbitration on contention;
// undefined -> fixed priority with the LSU always winning.

module ysyx_22041207_mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        if_req,
    input  logic [63:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [63:0] if_rdata,

    input  logic        ls_req,
    input  logic        ls_wen,
    input  logic [63:0] ls_addr,
    input  logic [63:0] ls_wdata,
    input  logic [7:0]  ls_wmask,
    input  logic [3:0]  ls_rnum,
    output logic        ls_gnt,
    output logic        ls_rvalid,
    output logic [63:0] ls_rdata,

    output logic        mem_req,
    output logic        mem_wen,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    output logic [3:0]  mem_rnum,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [63:0] mem_rdata,

    output logic        err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_e;

    // Fetch requests always go out as 4-byte reads.
    localparam logic [3:0] IF_RNUM = 4'd4;

    // Last counter value before abort; the counter reads 0 in the first BUSY cycle,
    // so the abort lands in cycle TIMEOUT_CYCLES of the transaction.
    localparam logic        TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0] TO_LAST = TO_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

    state_e      state_q;
    logic        owner_ls_q;     // 1: LSU owns the outstanding transaction
    logic        if_gnt_q;
    logic        ls_gnt_q;
    logic        wen_q;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;
    logic [7:0]  wmask_q;
    logic [3:0]  rnum_q;
    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    logic        any_req;
    logic        grant_ls;
    logic        active;
    logic        done_ok;
    logic        timeout;

    assign any_req = if_req | ls_req;

`ifdef YSYX_22041207_ARB_RR_EN
    // Preferred requester on contention; flips to the other side after every grant.
    logic prio_ls_q;

    assign grant_ls = ls_req & (~if_req | prio_ls_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_ls_q <= 1'b1;
        end else if (state_q == S_IDLE && any_req) begin
            prio_ls_q <= ~grant_ls;
        end
    end
`else
    assign grant_ls = ls_req;
`endif

    assign active  = (state_q != S_IDLE);
    assign done_ok = (state_q == S_RESP) & mem_rvalid;
    // A real response in the same cycle as the timeout still completes normally.
    assign timeout = TO_EN & active & (cnt_q == TO_LAST) & ~done_ok;

    // Saturate so a disabled timeout never wraps back into a false match.
    assign cnt_d = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            owner_ls_q <= 1'b0;
            if_gnt_q   <= 1'b0;
            ls_gnt_q   <= 1'b0;
            wen_q      <= 1'b0;
            addr_q     <= 64'd0;
            wdata_q    <= 64'd0;
            wmask_q    <= 8'd0;
            rnum_q     <= 4'd0;
            cnt_q      <= 32'd0;
        end else begin
            // Grants are single-cycle pulses in the first BUSY cycle.
            if_gnt_q <= 1'b0;
            ls_gnt_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (any_req) begin
                        state_q    <= S_BUSY;
                        owner_ls_q <= grant_ls;
                        cnt_q      <= 32'd0;
                        if (grant_ls) begin
                            ls_gnt_q <= 1'b1;
                            wen_q    <= ls_wen;
                            addr_q   <= ls_addr;
                            wdata_q  <= ls_wdata;
                            wmask_q  <= ls_wmask;
                            rnum_q   <= ls_rnum;
                        end else begin
                            if_gnt_q <= 1'b1;
                            wen_q    <= 1'b0;
                            addr_q   <= if_addr;
                            wdata_q  <= 64'd0;
                            wmask_q  <= 8'd0;
                            rnum_q   <= IF_RNUM;
                        end
                    end
                end
                S_BUSY: begin
                    cnt_q <= cnt_d;
                    if (timeout) begin
                        state_q <= S_IDLE;
                    end else if (mem_ready) begin
                        state_q <= S_RESP;
                    end
                end
                S_RESP: begin
                    cnt_q <= cnt_d;
                    if (done_ok || timeout) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign if_gnt    = if_gnt_q;
    assign ls_gnt    = ls_gnt_q;

    assign mem_req   = (state_q == S_BUSY);
    assign mem_wen   = wen_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wmask = wmask_q;
    assign mem_rnum  = rnum_q;

    // Responses pass straight through in the mem_rvalid cycle; an abort returns zero data.
    assign if_rvalid = (done_ok | timeout) & ~owner_ls_q;
    assign ls_rvalid = (done_ok | timeout) &  owner_ls_q;
    assign if_rdata  = (done_ok & ~owner_ls_q) ? mem_rdata : 64'd0;
    assign ls_rdata  = (done_ok &  owner_ls_q) ? mem_rdata : 64'd0;

    assign err       = timeout;

endmodule

// File: tb/tb_ysyx_22041207_mem_arbiter.sv
// Purpose : self-checking bench for the memory arbiter; responses are scored against a queue of expectations.
// Latency : inputs driven 1ns after the rising edge, outputs sampled on the falling edge.
// Backpressure: the bench plays the memory, choosing when mem_ready and mem_rvalid arrive.

module tb_ysyx_22041207_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [63:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [63:0] if_rdata;
    logic        ls_req;
    logic        ls_wen;
    logic [63:0] ls_addr;
    logic [63:0] ls_wdata;
    logic [7:0]  ls_wmask;
    logic [3:0]  ls_rnum;
    logic        ls_gnt;
    logic        ls_rvalid;
    logic [63:0] ls_rdata;
    logic        mem_req;
    logic        mem_wen;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic [3:0]  mem_rnum;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;
    logic        err;

    always #5 clk = ~clk;

    ysyx_22041207_mem_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .ls_req     (ls_req),
        .ls_wen     (ls_wen),
        .ls_addr    (ls_addr),
        .ls_wdata   (ls_wdata),
        .ls_wmask   (ls_wmask),
        .ls_rnum    (ls_rnum),
        .ls_gnt     (ls_gnt),
        .ls_rvalid  (ls_rvalid),
        .ls_rdata   (ls_rdata),
        .mem_req    (mem_req),
        .mem_wen    (mem_wen),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wmask  (mem_wmask),
        .mem_rnum   (mem_rnum),
        .mem_ready  (mem_ready),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .err        (err)
    );

    typedef struct {
        bit          is_ls;
        logic [63:0] data;
        bit          err;
        bit          chk_data;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Response monitor: every rvalid must match the oldest outstanding expectation.
    exp_t e;
    always @(negedge clk) begin
        if (!rst && (if_rvalid || ls_rvalid)) begin
            if (sb_q.size() == 0) begin
                check_eq("unexpected_rvalid", {62'd0, ls_rvalid, if_rvalid}, 64'd0);
            end else begin
                e = sb_q.pop_front();
                check_eq("rsp_if_rvalid", 64'(if_rvalid), 64'(!e.is_ls));
                check_eq("rsp_ls_rvalid", 64'(ls_rvalid), 64'(e.is_ls));
                check_eq("rsp_err", 64'(err), 64'(e.err));
                if (e.chk_data)
                    check_eq("rsp_rdata", e.is_ls ? ls_rdata : if_rdata, e.data);
                check_eq("rsp_other_rdata", e.is_ls ? if_rdata : ls_rdata, 64'd0);
            end
        end
    end

    // Entered 1ns into the first BUSY cycle: check grant/payload, answer with
    // mem_ready now and mem_rvalid next cycle. Returns on the falling edge of the following IDLE cycle.
    task automatic serve(input bit w_ls, input logic [63:0] addr, input bit wen,
                         input logic [7:0] wmask, input logic [63:0] wdata,
                         input logic [3:0] rnum, input logic [63:0] rdata, input bit chk_data);
        if (w_ls) ls_req = 1'b0; else if_req = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        check_eq("gnt_winner", 64'(w_ls ? ls_gnt : if_gnt), 64'd1);
        check_eq("gnt_loser", 64'(w_ls ? if_gnt : ls_gnt), 64'd0);
        check_eq("busy_mem_req", 64'(mem_req), 64'd1);
        check_eq("mem_addr", mem_addr, addr);
        check_eq("mem_wen", 64'(mem_wen), 64'(wen));
        check_eq("mem_wmask", 64'(mem_wmask), 64'(wmask));
        check_eq("mem_wdata", mem_wdata, wdata);
        check_eq("mem_rnum", 64'(mem_rnum), 64'(rnum));
        sb_q.push_back('{w_ls, rdata, 1'b0, chk_data});
        step();
        mem_ready  = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        @(negedge clk);
        check_eq("resp_mem_req", 64'(mem_req), 64'd0);
        check_eq("resp_gnt_clear", 64'({if_gnt, ls_gnt}), 64'd0);
        step();
        mem_rvalid = 1'b0;
        mem_rdata  = 64'd0;
        @(negedge clk);
        check_eq("idle_mem_req", 64'(mem_req), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        if_req = 1'b0; if_addr = 64'd0;
        ls_req = 1'b0; ls_wen = 1'b0; ls_addr = 64'd0; ls_wdata = 64'd0;
        ls_wmask = 8'd0; ls_rnum = 4'd0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 64'd0;

        // Reset state
        repeat (2) @(negedge clk);
        check_eq("rst_ctrl", 64'({if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_req, mem_wen, err}), 64'd0);
        check_eq("rst_rdata", if_rdata | ls_rdata, 64'd0);
        check_eq("rst_payload", mem_addr | mem_wdata | 64'(mem_wmask) | 64'(mem_rnum), 64'd0);
        step();
        rst = 1'b0;

        // Contention from reset: LSU first, then the waiting IFU
        if_req = 1'b1; if_addr = 64'h8000_0100;
        ls_req = 1'b1; ls_addr = 64'h8000_2000; ls_rnum = 4'd8;
        step();
        serve(1'b1, 64'h8000_2000, 1'b0, 8'h00, 64'd0, 4'd8, 64'h1111_2222_3333_4444, 1'b1);
        step();
        serve(1'b0, 64'h8000_0100, 1'b0, 8'h00, 64'd0, 4'd4, 64'h0000_0000_0000_0013, 1'b1);

        // Second contention with the LSU reissuing while the IFU still waits
        if_req = 1'b1; if_addr = 64'h8000_0200;
        ls_req = 1'b1; ls_addr = 64'h8000_3000;
        step();
        serve(1'b1, 64'h8000_3000, 1'b0, 8'h00, 64'd0, 4'd8, 64'hAAAA_0000_0000_0001, 1'b1);
        ls_req = 1'b1; ls_addr = 64'h8000_3008;
        step();
`ifdef YSYX_22041207_ARB_RR_EN
        serve(1'b0, 64'h8000_0200, 1'b0, 8'h00, 64'd0, 4'd4, 64'hBBBB_0000_0000_0002, 1'b1);
        step();
        serve(1'b1, 64'h8000_3008, 1'b0, 8'h00, 64'd0, 4'd8, 64'hCCCC_0000_0000_0003, 1'b1);
`else
        serve(1'b1, 64'h8000_3008, 1'b0, 8'h00, 64'd0, 4'd8, 64'hCCCC_0000_0000_0003, 1'b1);
        step();
        serve(1'b0, 64'h8000_0200, 1'b0, 8'h00, 64'd0, 4'd4, 64'hBBBB_0000_0000_0002, 1'b1);
`endif

        // Single fetch
        if_req = 1'b1; if_addr = 64'h8000_0000;
        step();
        serve(1'b0, 64'h8000_0000, 1'b0, 8'h00, 64'd0, 4'd4, 64'h0000_0000_0000_0413, 1'b1);

        // Store: read data is don't-care
        ls_req = 1'b1; ls_wen = 1'b1; ls_addr = 64'h8000_1000;
        ls_wdata = 64'h1234_5678; ls_wmask = 8'h0F; ls_rnum = 4'd0;
        step();
        serve(1'b1, 64'h8000_1000, 1'b1, 8'h0F, 64'h1234_5678, 4'd0, 64'hDEAD_BEEF, 1'b0);
        ls_wen = 1'b0; ls_wdata = 64'd0; ls_wmask = 8'd0; ls_rnum = 4'd8;

        // Timeout in BUSY: mem_ready never comes, a stray mem_rvalid is ignored
        ls_req = 1'b1; ls_addr = 64'h8000_4000;
        step();
        ls_req = 1'b0;
        sb_q.push_back('{1'b1, 64'd0, 1'b1, 1'b1});
        @(negedge clk);
        check_eq("to_busy_gnt", 64'(ls_gnt), 64'd1);
        check_eq("to_busy_err1", 64'(err), 64'd0);
        for (int i = 0; i < 2; i++) begin
            step();
            mem_rvalid = (i == 0);
            mem_rdata  = 64'h5555;
            @(negedge clk);
            check_eq("to_busy_early_err", 64'(err), 64'd0);
            check_eq("to_busy_mem_req", 64'(mem_req), 64'd1);
        end
        step();
        mem_rvalid = 1'b0;
        @(negedge clk);
        check_eq("to_busy_err", 64'(err), 64'd1);
        step();
        @(negedge clk);
        check_eq("to_busy_after", 64'({err, mem_req, ls_rvalid}), 64'd0);

        // Timeout in RESP: accepted but mem_rvalid never arrives
        if_req = 1'b1; if_addr = 64'h8000_0400;
        step();
        if_req = 1'b0;
        mem_ready = 1'b1;
        sb_q.push_back('{1'b0, 64'd0, 1'b1, 1'b1});
        step();
        mem_ready = 1'b0;
        @(negedge clk);
        check_eq("to_resp_early", 64'({err, mem_req, if_rvalid}), 64'd0);
        step();
        @(negedge clk);
        check_eq("to_resp_early2", 64'(err), 64'd0);
        step();
        @(negedge clk);
        check_eq("to_resp_err", 64'(err), 64'd1);
        step();
        @(negedge clk);
        check_eq("to_resp_after", 64'({err, if_rvalid}), 64'd0);

        // Stray mem_rvalid in IDLE with no request
        step();
        mem_rvalid = 1'b1; mem_rdata = 64'hFFFF_FFFF;
        @(negedge clk);
        check_eq("stray_rvalid", 64'({if_rvalid, ls_rvalid}), 64'd0);
        step();
        mem_rvalid = 1'b0;
        @(negedge clk);
        check_eq("stray_idle", 64'(mem_req), 64'd0);

        // Reset while waiting in RESP
        ls_req = 1'b1; ls_addr = 64'h8000_5000;
        step();
        ls_req = 1'b0;
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_resp_ctrl", 64'({if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_req, mem_wen, err}), 64'd0);
        check_eq("rst_resp_addr", mem_addr, 64'd0);
        step();
        rst = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 64'h7777;
        @(negedge clk);
        check_eq("rst_late_rvalid", 64'({if_rvalid, ls_rvalid, err}), 64'd0);
        step();
        mem_rvalid = 1'b0;
        ls_req = 1'b1; ls_addr = 64'h8000_5000;
        step();
        serve(1'b1, 64'h8000_5000, 1'b0, 8'h00, 64'd0, 4'd8, 64'h0BAD_F00D_0000_0001, 1'b1);

        check_eq("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
